// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: 32x32 register file, busy scoreboard interlock,
// and a valid/ready pipeline register feeding {instr, regA, regB} to execute.
module operand_fetch #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_regA,
  output logic [31:0] ex_regB
);

  // Handshake: a transfer happens on a rising edge only when valid and ready
  // are both high; ex_* hold while ex_valid && !ex_ready, and if_ready never
  // looks at if_valid.

  function automatic logic [4:0] dest_of(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == 6'd0)
      return instr[15:11];
    else if (op[5:1] == 5'b00001 || op == 6'h04 || op == 6'h05 || op == 6'h2b)
      return 5'd0;
    else
      return instr[20:16];
  endfunction

  logic [31:0] regs [32];
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic [31:0] wb_vec;
  logic [31:0] eff_busy;

  logic [5:0]  op;
  logic [4:0]  rs, rt, dest, ex_dest;
  logic        use_rs, use_rt;
  logic        hazard;
  logic        issue;
  logic [31:0] rd_a, rd_b;

  assign op      = if_instr[31:26];
  assign rs      = if_instr[25:21];
  assign rt      = if_instr[20:16];
  assign dest    = dest_of(if_instr);
  assign ex_dest = dest_of(ex_instr);

  assign use_rs = (op[5:1] != 5'b00001);
  assign use_rt = (op == 6'd0) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);

  // A writeback in this cycle releases its bit before the hazard check.
  assign wb_vec   = wb_en ? (32'd1 << wb_addr) : 32'd0;
  assign eff_busy = busy & ~wb_vec;

  assign hazard = (use_rs && eff_busy[rs]) || (use_rt && eff_busy[rt]) || eff_busy[dest];

  assign if_ready = rst_n && !flush && !hazard && (!ex_valid || ex_ready);
  assign issue    = if_valid && if_ready;

  // Write-through reads so a same-cycle writeback is seen by the issuing instruction.
  assign rd_a = (rs == 5'd0) ? 32'd0 : ((wb_en && wb_addr == rs) ? wb_data : regs[rs]);
  assign rd_b = (rt == 5'd0) ? 32'd0 : ((wb_en && wb_addr == rt) ? wb_data : regs[rt]);

  always_comb begin
    busy_nxt = busy & ~wb_vec;
    if (flush && ex_valid)
      busy_nxt = busy_nxt & ~(32'd1 << ex_dest);
    // Set after clear: a new issue to the same register keeps it busy.
    if (issue)
      busy_nxt = busy_nxt | (32'd1 << dest);
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 32'd0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_instr <= RESET_INSTR;
      ex_regA  <= 32'd0;
      ex_regB  <= 32'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_instr <= RESET_INSTR;
      ex_regA  <= 32'd0;
      ex_regB  <= 32'd0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_instr <= if_instr;
      ex_regA  <= rd_a;
      ex_regB  <= rd_b;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a driver feeds directed and random
// traffic into a register/pending-write model; a monitor checks EX entries.
module tb_operand_fetch;

  localparam logic [31:0] RST_I = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_instr, ex_regA, ex_regB;

  operand_fetch #(.RESET_INSTR(RST_I)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_regA(ex_regA), .ex_regB(ex_regB)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [95:0] exp_q[$];
  logic [95:0] idle_exp;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  // Reference model: architectural values, registers with a write still owed,
  // and the destination of whatever sits in the EX slot.
  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          m_exv;
  logic [4:0]  m_dest;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'd0;
      mpend[i] = 0;
    end
    m_exv = 0;
    m_dest = 5'd0;
    exp_q.delete();
    idle_exp = {RST_I, 64'd0};
  endtask

  // What an instruction reads and writes, straight from the opcode table.
  task automatic decode(input logic [31:0] i, output bit ua, output bit ub, output logic [4:0] d);
    case (i[31:26])
      6'h00:                    begin ua = 1; ub = 1; d = i[15:11]; end
      6'h02, 6'h03:             begin ua = 0; ub = 0; d = 5'd0;     end
      6'h04, 6'h05, 6'h2b:      begin ua = 1; ub = 1; d = 5'd0;     end
      default:                  begin ua = 1; ub = 0; d = i[20:16]; end
    endcase
  endtask

  function automatic bit owed(input logic [4:0] r, input logic we, input logic [4:0] wa);
    return (r != 0) && mpend[r] && !(we && wa == r);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  // Driver: one clock of stimulus, with the model advanced at the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic fl, input logic er,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bit ua, ub, exp_rdy, iss;
    logic [4:0] d;
    logic [95:0] ent;
    @(negedge clk);
    if_valid = v; if_instr = ins; flush = fl; ex_ready = er;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    decode(ins, ua, ub, d);
    exp_rdy = !fl && !(ua && owed(ins[25:21], we, wa)) && !(ub && owed(ins[20:16], we, wa))
              && !owed(d, we, wa) && (!m_exv || er);
    chk("if_ready", {95'd0, if_ready}, {95'd0, exp_rdy});
    iss = v && exp_rdy;
    ent = {ins, mread(ins[25:21], we, wa, wd), mread(ins[20:16], we, wa, wd)};
    @(posedge clk);
    if (we) begin
      if (wa != 0) mregs[wa] = wd;
      mpend[wa] = 0;
    end
    if (fl) begin
      if (m_exv) mpend[m_dest] = 0;
      m_exv = 0;
    end else if (iss) begin
      exp_q.push_back(ent);
      m_exv = 1;
      m_dest = d;
      if (d != 0) mpend[d] = 1;
    end else if (m_exv && er) begin
      m_exv = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: inputs settled, entry about to be consumed or flushed.
  initial begin
    logic [95:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !done) begin
        got = {ex_instr, ex_regA, ex_regB};
        chk("ex_valid", {95'd0, ex_valid}, {95'd0, exp_q.size() != 0});
        if (ex_valid && exp_q.size() != 0) begin
          chk("ex_entry", got, exp_q[0]);
          if (flush) begin
            void'(exp_q.pop_front());
            idle_exp = {RST_I, 64'd0};
          end else if (ex_ready) begin
            idle_exp = exp_q.pop_front();
          end
        end else if (!ex_valid) begin
          chk("ex_hold", got, idle_exp);
          if (flush) idle_exp = {RST_I, 64'd0};
        end
      end
    end
  end

  // Stimulus
  initial begin
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_ex_valid", {95'd0, ex_valid}, 96'd0);
    chk("rst_if_ready", {95'd0, if_ready}, 96'd0);
    chk("rst_ex_data", {ex_instr, ex_regA, ex_regB}, {RST_I, 64'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // reg1=5, reg2=3, then add $3,$1,$2
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'd5);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2, 32'd3);
    cycle(1'b1, 32'h0022_1820, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    // sub $4,$3,$1 blocked by $3, then released by a same-cycle writeback of 8
    cycle(1'b1, 32'h0061_2022, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 32'h0061_2022, 1'b0, 1'b1, 1'b1, 5'd3, 32'd8);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'd77);
    // reg0 ignores writes; addu $5,$0,$0
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 32'h0000_2821, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd5, 32'd9);
    // stall three cycles with a ready-to-go instruction waiting
    cycle(1'b1, 32'h2027_0004, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2028_0002, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 32'h2028_0002, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'd11);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd8, 32'd12);
    // addi $6,$1,1 stalled then flushed; $6 must be free again
    cycle(1'b1, 32'h2026_0001, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 32'h20C7_0001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 32'h20C7_0001, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'd13);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] ops [9];
      logic [31:0] ins;
      logic [4:0] wa;
      int pick;
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2b, 6'h08, 6'h23, 6'h0d};
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 8)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      wa = 5'($urandom_range(0, 7));
      pick = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++)
        if (mpend[(pick + k) % 8]) wa = 5'((pick + k) % 8);
      cycle(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), wa, $urandom);
    end

    // Asynchronous reset in the middle of a stall.
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'd21);
    cycle(1'b1, 32'h2026_0001, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {95'd0, ex_valid}, 96'd0);
    chk("async_rst_ready", {95'd0, if_ready}, 96'd0);
    chk("async_rst_data", {ex_instr, ex_regA, ex_regB}, {RST_I, 64'd0});
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    // $6 free and reg1 reads 0 again
    cycle(1'b1, 32'h2026_0001, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 32'h0026_3820, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(3);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
